// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector: default parameters,
// the history-register action encoding and the counter saturation helper.
package seq_det_pkg;

    localparam int          DEF_PAT_W   = 3;
    localparam logic [2:0]  DEF_PATTERN = 3'b101;
    localparam int          DEF_CNT_W   = 8;

    // What the history/fill registers do at the next edge.
    typedef enum logic [1:0] {
        HIST_HOLD  = 2'd0,
        HIST_SHIFT = 2'd1,
        HIST_CLEAR = 2'd2
    } hist_act_e;

    // All-ones value of a w-bit counter (w in 1..32).
    function automatic logic [31:0] sat_limit(input int unsigned w);
        logic [31:0] lim;
        if (w >= 32'd32) begin
            lim = 32'hFFFF_FFFF;
        end else begin
            lim = (32'd1 << w) - 32'd1;
        end
        return lim;
    endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter with synchronous reset, clear and increment.
// Clear wins over increment, so a match coinciding with a clear is dropped.
module seq_match_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_limit(CNT_W));

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;

    // Next count: reset/clear to zero, else increment unless already saturated.
    always_comb begin
        count_next_s = count_r;
        if (rst || clr) begin
            count_next_s = '0;
        end else if (inc && (count_r != CNT_MAX)) begin
            count_next_s = count_r + CNT_W'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        count_r <= count_next_s;
    end

    assign count = count_r;

endmodule

// File: rtl/seq_pattern_detector.sv
// Mealy serial pattern detector. Accepted bits shift into a history register
// (newest at LSB); once PAT_W-1 bits are held, the incoming bit completes a
// candidate word that is compared against the active pattern in the same cycle.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
    parameter logic             OVERLAP = 1'b1,
    parameter int               CNT_W   = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             A,
    input  logic             PAT_LOAD,
    input  logic [PAT_W-1:0] PAT_IN,
    input  logic             CNT_CLR,
    output logic             Y,
    output logic             Y_Q,
    output logic [CNT_W-1:0] COUNT,
    output logic [PAT_W-1:0] ACTIVE_PAT
);

    localparam int               FILL_W    = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0]  hist_r;
    logic [FILL_W-1:0] fill_r;
    logic [PAT_W-1:0]  pat_r;
    logic              y_q_r;

    logic [PAT_W-1:0]  cand_s;
    logic [FILL_W-1:0] fill_inc_s;
    logic              y_s;
    hist_act_e         hist_act_s;

    assign cand_s = {hist_r, A};

    // Match strobe and history action for the coming edge.
    always_comb begin
        y_s        = 1'b0;
        hist_act_s = HIST_HOLD;
        fill_inc_s = fill_r;

        if (fill_r == FILL_FULL) begin
            fill_inc_s = fill_r;
        end else begin
            fill_inc_s = fill_r + FILL_W'(1);
        end

        if (!RESET && !PAT_LOAD && EN && (fill_r == FILL_FULL) && (cand_s == pat_r)) begin
            y_s = 1'b1;
        end else begin
            y_s = 1'b0;
        end

        if (RESET || PAT_LOAD) begin
            hist_act_s = HIST_CLEAR;
        end else if (y_s && !OVERLAP) begin
            hist_act_s = HIST_CLEAR;
        end else if (EN) begin
            hist_act_s = HIST_SHIFT;
        end else begin
            hist_act_s = HIST_HOLD;
        end
    end

    // History shift register and fill level.
    always_ff @(posedge CLK) begin
        case (hist_act_s)
            HIST_SHIFT: begin
                hist_r <= cand_s[PAT_W-2:0];
                fill_r <= fill_inc_s;
            end
            HIST_HOLD: begin
                hist_r <= hist_r;
                fill_r <= fill_r;
            end
            HIST_CLEAR: begin
                hist_r <= '0;
                fill_r <= '0;
            end
            default: begin
                hist_r <= '0;
                fill_r <= '0;
            end
        endcase
    end

    // Active pattern: reset default, or reloaded from PAT_IN.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pat_r <= PATTERN;
        end else if (PAT_LOAD) begin
            pat_r <= PAT_IN;
        end else begin
            pat_r <= pat_r;
        end
    end

    // Registered, glitch-free copy of the match strobe.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            y_q_r <= 1'b0;
        end else begin
            y_q_r <= y_s;
        end
    end

    seq_match_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (CLK),
        .rst   (RESET),
        .clr   (CNT_CLR),
        .inc   (y_s),
        .count (COUNT)
    );

    assign Y          = y_s;
    assign Y_Q        = y_q_r;
    assign ACTIVE_PAT = pat_r;

endmodule

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

Parametrised Mealy serial-pattern detector: a generalised 101 detector. It watches a qualified serial bit stream and flags, in the same cycle, the arrival of the final bit of a programmable PAT_W-bit pattern. It supports overlapping or non-overlapping matching, runtime pattern reload, and a saturating match counter. It sits directly behind a serial input (or deserialiser tap) and feeds match strobes and statistics to control logic.

## Interface
- PAT_W, 3: pattern length in bits, 2..16.
- PATTERN, 3'b101: reset/default pattern; MSB is the first bit received.
- OVERLAP, 1: 1 means a match's tail bits may start the next match; 0 means history is discarded after each match.
- CNT_W, 8: match counter width.
- CLK  input  1  clock; all state updates on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- EN  input  1  A is a valid sample this cycle; when low, state holds.
- A  input  1  serial data bit.
- PAT_LOAD  input  1  load PAT_IN as the active pattern at the next edge.
- PAT_IN  input  PAT_W  new pattern value.
- CNT_CLR  input  1  synchronous clear of COUNT.
- Y  output  1  Mealy match, combinational from A, EN and state.
- Y_Q  output  1  Y registered one cycle (glitch-free copy).
- COUNT  output  CNT_W  saturating number of matches.
- ACTIVE_PAT  output  PAT_W  currently active pattern.

## Operation
- State: history shift register HIST[PAT_W-2:0] (newest bit at LSB), fill counter FILL (0..PAT_W-1), active pattern register PAT, COUNT, Y_Q.
- Candidate word: {HIST, A}.
- Y = EN & ~RESET & ~PAT_LOAD & (FILL == PAT_W-1) & ({HIST, A} == PAT).
- On an edge with EN=1 and no match: HIST <= {HIST[PAT_W-3:0], A}; FILL <= min(FILL+1, PAT_W-1).
- On an edge with a match:
  - OVERLAP=1: same shift as a non-match.
  - OVERLAP=0: HIST <= 0; FILL <= 0.
- EN=0: HIST, FILL, COUNT hold; Y=0.
- PAT_LOAD=1: PAT <= PAT_IN; HIST <= 0; FILL <= 0; Y is forced 0 that cycle; that cycle's A is discarded. PAT_LOAD overrides EN.
- COUNT <= COUNT+1 on each match, saturating at 2^CNT_W-1. CNT_CLR has priority over increment, so a simultaneous match is not counted.
- RESET=1: PAT <= PATTERN; HIST, FILL, COUNT, Y_Q <= 0; Y forced 0. RESET overrides PAT_LOAD and CNT_CLR.
- Reset mid-sequence discards partial history; detection restarts from empty.

## Timing
- Y latency: 0 cycles. It is valid in the same cycle as the final pattern bit, before the capturing edge.
- Y_Q = Y delayed exactly one edge.
- COUNT reflects a match one edge after Y.
- ACTIVE_PAT changes one edge after PAT_LOAD.
- The first match is possible on the PAT_W-th accepted bit after reset, load, or a non-overlap match.
- Reset values: Y=0, Y_Q=0, COUNT=0, ACTIVE_PAT=PATTERN.

## Structure
- Shared package seq_det_pkg holds:
  - default constants DEF_PAT_W=3, DEF_PATTERN=3'b101, DEF_CNT_W=8;
  - a localparam function for the saturation limit.
- One natural sub-module: seq_match_counter, the CNT_W saturating counter with clear and increment inputs.
- Everything else stays in the top module: a history/FILL register process plus a separate combinational match/Y process.

## Test plan
- Default params: reset 2 cycles, then A=1,0,1,0,1 with EN=1 -> Y pulses on the 3rd and 5th bits (overlap); COUNT=2; Y_Q lags Y by 1.
- OVERLAP=0, same stream 1,0,1,0,1 -> Y only on the 3rd bit; the 5th bit gives no match; COUNT=1.
- PAT_LOAD with PAT_IN=3'b110, then stream 1,1,0 -> Y on the 3rd bit; stream 0,1,1 -> no Y (checks bit order); ACTIVE_PAT=3'b110 one edge after load.
- EN gaps: 1,(EN=0 ×3),0,1 -> Y on the final bit only; Y=0 whenever EN=0.
- CNT_W=2, 5 overlapping matches -> COUNT saturates at 3; CNT_CLR coincident with a match -> COUNT=0 next edge.
- RESET asserted after bits 1,0, then bit 1 -> no Y; COUNT=0; ACTIVE_PAT returns to 3'b101.
